// File: rtl/dmem_rsp.sv
// Data-memory responder: one load/store at a time against a doubleword array,
// fixed-latency response with right-justified load data and access-error flag.
module dmem_rsp #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         AW     = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [63:0] mem [DEPTH];
  logic [63:0] rdata_p0;
  logic        err_p0;

  logic          accept;
  logic [AW-1:0] idx;
  logic [2:0]    off;
  logic          misalign;
  logic          oor;
  logic          acc_err;

  function automatic logic is_misaligned(input logic [2:0] o, input logic [1:0] size);
    logic [2:0] m;
    m = 3'((4'd1 << size) - 4'd1);
    return (o & m) != 3'd0;
  endfunction

  // Shift the selected lanes down to bit 0 and clear everything above the access width.
  function automatic logic [63:0] fmt_load(input logic [63:0] dw, input logic [2:0] o,
                                           input logic [1:0] size);
    logic [63:0] sh;
    logic [63:0] mask;
    sh = dw >> {o, 3'b000};
    case (size)
      2'd0:    mask = 64'h0000_0000_0000_00FF;
      2'd1:    mask = 64'h0000_0000_0000_FFFF;
      2'd2:    mask = 64'h0000_0000_FFFF_FFFF;
      default: mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return sh & mask;
  endfunction

  function automatic logic [63:0] merge_store(input logic [63:0] dw, input logic [63:0] wd,
                                              input logic [2:0] o, input logic [1:0] size);
    logic [63:0] res;
    int          nb;
    int          oi;
    res = dw;
    nb  = 1 << size;
    oi  = int'(o);
    for (int i = 0; i < 8; i++) begin
      if (i >= oi && i < oi + nb) res[8*i +: 8] = wd[8*(i-oi) +: 8];
    end
    return res;
  endfunction

  assign idx      = req_addr[AW+2:3];
  assign off      = req_addr[2:0];
  assign misalign = is_misaligned(off, req_size);
  assign oor      = |req_addr[63:AW+3];
  assign acc_err  = misalign | oor;
  assign accept   = req_valid & (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (LATENCY == 1) begin
            state_nxt = RESP;
          end else begin
            state_nxt = BUSY;
            cnt_nxt   = LAT_M1;
          end
        end
      end
      BUSY: begin
        if (cnt == 4'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Accept stage: array update and response capture happen on the accept edge.
  always_ff @(posedge clk) begin
    if (accept && req_we && !acc_err) begin
      mem[idx] <= merge_store(mem[idx], req_wdata, off, req_size);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      rdata_p0 <= (req_we || acc_err) ? 64'd0 : fmt_load(mem[idx], off, req_size);
      err_p0   <= acc_err;
    end
  end

  // Data registers are not reset, so outputs are qualified by the response state.
  assign rsp_rdata = (state == RESP) ? rdata_p0 : 64'd0;
  assign rsp_err   = (state == RESP) ? err_p0 : 1'b0;

endmodule
